ysyx_25020037_icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the IFU and its AXI refill path.

---
 rtl/ysyx_25020037_icache.sv | 165 ++++++++++++++++
 tb/tb_ysyx_25020037_icache.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_icache.sv
// ============================================================================
//  Module      : ysyx_25020037_icache
//  Description : Direct-mapped, read-only instruction cache sitting between
//                the IFU and its AXI refill path. Each fetch address is looked
//                up one cycle after the request strobe. A hit returns the
//                cached word. A miss issues a line refill and delivers the
//                requested word from the returned block. Also provides a
//                fence.i flush and saturating hit/miss counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   clock
//    rst           in   asynchronous active-high reset
//    icache_req    in   1-cycle lookup strobe (accepted in IDLE only)
//    icache_addr   in   fetch address, sampled with icache_req
//    icache_hit    out  lookup hit, held until the next icache_req
//    icache_data   out  instruction word, held until the next icache_req
//    icache_ready  out  1-cycle pulse when a lookup or refill finishes
//    mem_req       out  refill request, held until mem_ready
//    mem_addr      out  line-aligned refill address
//    mem_data      in   refill block, word0 in bits [31:0]
//    mem_ready     in   1-cycle pulse, mem_data valid
//    mem_err       in   qualifies mem_ready: refill faulted
//    fence_i       in   invalidate every line
//    hit_cnt       out  saturating hit counter
//    miss_cnt      out  saturating miss counter
// ============================================================================
`default_nettype none

module ysyx_25020037_icache #(
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    icache_req,
  input  logic [31:0]             icache_addr,
  output logic                    icache_hit,
  output logic [31:0]             icache_data,
  output logic                    icache_ready,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_data,
  input  logic                    mem_ready,
  input  logic                    mem_err,
  input  logic                    fence_i,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int OFFSET_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W    = $clog2(NUM_LINES);
  localparam int TAG_W    = 32 - OFFSET_W - IDX_W;
  localparam int LINE_W   = BLOCK_SIZE * 8;
  localparam int WORDS    = BLOCK_SIZE / 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t                  r_state;
  logic [31:0]             r_addr_q;
  logic [NUM_LINES-1:0]    r_valid;
  // Set when fence_i arrives while a refill is outstanding, so that the
  // returning line is delivered but never validated.
  logic                    r_flush_pend;
  logic [TAG_W-1:0]        r_tag  [NUM_LINES];
  logic [LINE_W-1:0]       r_data [NUM_LINES];

  logic [TAG_W-1:0]        w_tag_q;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_hit;
  logic [31:0]             w_line_word;
  logic [31:0]             w_mem_word;
  logic                    w_unused;

  assign w_tag_q  = r_addr_q[31 -: TAG_W];
  assign w_idx    = r_addr_q[OFFSET_W +: IDX_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag_q);
  assign w_unused = &{1'b0, r_addr_q[1:0]};

  // Word selection within a line; a 4-byte line holds exactly one word.
  generate
    if (WORDS > 1) begin : g_word_sel
      logic [WORDS-1:0][31:0] w_line_words;
      logic [WORDS-1:0][31:0] w_mem_words;
      assign w_line_words = r_data[w_idx];
      assign w_mem_words  = mem_data;
      assign w_line_word  = w_line_words[r_addr_q[OFFSET_W-1:2]];
      assign w_mem_word   = w_mem_words[r_addr_q[OFFSET_W-1:2]];
    end else begin : g_word_single
      assign w_line_word = r_data[w_idx][31:0];
      assign w_mem_word  = mem_data[31:0];
    end
  endgenerate

  // Control FSM, valid bits and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr_q     <= '0;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      icache_hit   <= 1'b0;
      icache_data  <= '0;
      icache_ready <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      icache_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (icache_req) begin
            r_addr_q   <= icache_addr;
            icache_hit <= 1'b0;
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            icache_hit   <= 1'b1;
            icache_data  <= w_line_word;
            icache_ready <= 1'b1;
            if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            r_state      <= S_IDLE;
          end else begin
            mem_req      <= 1'b1;
            mem_addr     <= {r_addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
            r_flush_pend <= 1'b0;
            if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            r_state      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (fence_i) r_flush_pend <= 1'b1;
          if (mem_ready) begin
            mem_req      <= 1'b0;
            icache_ready <= 1'b1;
            icache_data  <= mem_err ? 32'd0 : w_mem_word;
            if (!mem_err && !fence_i && !r_flush_pend) r_valid[w_idx] <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Flush wins over any valid-bit set made above in the same cycle.
      if (fence_i) r_valid <= '0;
    end
  end

  // Tag/data storage is not reset; the valid bits guard stale contents.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_REFILL && mem_ready && !mem_err) begin
      r_tag[w_idx]  <= w_tag_q;
      r_data[w_idx] <= mem_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020037_icache.sv
// ============================================================================
//  Module      : tb_ysyx_25020037_icache
//  Description : Self-checking bench for ysyx_25020037_icache (16-byte lines,
//                16 lines). A reference model of cache contents keyed by
//                line address predicts each response; expectations are
//                queued at issue time and a monitor compares them whenever
//                the cache signals icache_ready or raises mem_req.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25020037_icache;

  localparam int BS  = 16;
  localparam int NL  = 16;
  localparam int LW  = BS * 8;
  localparam int OFW = 4;
  localparam int IXW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_req;
  logic [31:0]   icache_addr;
  logic          icache_hit;
  logic [31:0]   icache_data;
  logic          icache_ready;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_data;
  logic          mem_ready;
  logic          mem_err;
  logic          fence_i;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  always #5 clk = ~clk;

  ysyx_25020037_icache #(.BLOCK_SIZE(BS), .NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_hit(icache_hit), .icache_data(icache_data),
    .icache_ready(icache_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .mem_err(mem_err), .fence_i(fence_i),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] refill_q[$];
  int          checks = 0;
  int          passes = 0;
  bit          abort  = 0;

  // Reference model: what each cache slot currently holds, by line address.
  bit          m_valid [NL];
  logic [31:0] m_line  [NL];
  logic [LW-1:0] m_block [NL];
  logic [31:0] m_hc, m_mc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic void m_flush();
    for (int i = 0; i < NL; i++) m_valid[i] = 0;
  endfunction

  function automatic void m_reset();
    m_flush();
    m_hc = 0;
    m_mc = 0;
  endfunction

  function automatic logic [LW-1:0] rand_block();
    logic [LW-1:0] b;
    for (int i = 0; i < BS / 4; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Monitor: compares every completed lookup/refill and every refill request.
  initial begin
    logic saw;
    logic prev;
    exp_t e;
    logic [31:0] a;
    saw  = 0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        saw  = 0;
        prev = 0;
      end else begin
        if (mem_req && !prev) begin
          saw = 1;
          if (refill_q.size() == 0) check("refill_expected", 32'(refill_q.size()), 32'd1);
          else begin
            a = refill_q.pop_front();
            check("mem_addr", mem_addr, a);
          end
        end
        prev = mem_req;
        if (icache_ready) begin
          if (exp_q.size() == 0) check("ready_expected", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            check("icache_hit", {31'd0, icache_hit}, {31'd0, e.hit});
            check("icache_data", icache_data, e.data);
            check("hit_cnt", hit_cnt, e.hc);
            check("miss_cnt", miss_cnt, e.mc);
            check("refill_seen", {31'd0, saw}, {31'd0, !e.hit});
          end
          saw = 0;
        end
      end
    end
  end

  // One fetch. fmode: 0 none, 1 fence with the request, 2 fence while the
  // refill is outstanding, 3 fence on the mem_ready cycle.
  task automatic txn(input logic [31:0] addr, input logic err, input int fmode_in,
                     input logic [LW-1:0] blk);
    int idx;
    int w;
    int lat;
    int d;
    int fmode;
    logic [31:0] line;
    bit mhit;
    exp_t e;
    if (abort) return;
    fmode = fmode_in;
    idx   = int'(addr[OFW +: IXW]);
    w     = int'(addr[OFW-1:2]);
    line  = {addr[31:OFW], 4'b0};
    if (fmode == 1) m_flush();
    mhit = m_valid[idx] && (m_line[idx] == line);
    if (mhit) begin
      if (fmode >= 2) fmode = 0;
      e.hit  = 1;
      e.data = m_block[idx][w*32 +: 32];
      if (m_hc != 32'hFFFF_FFFF) m_hc++;
    end else begin
      e.hit  = 0;
      e.data = err ? 32'd0 : blk[w*32 +: 32];
      if (m_mc != 32'hFFFF_FFFF) m_mc++;
      refill_q.push_back(line);
      if (fmode >= 2) m_flush();
      else if (!err) begin
        m_valid[idx] = 1;
        m_line[idx]  = line;
        m_block[idx] = blk;
      end
    end
    e.hc = m_hc;
    e.mc = m_mc;
    exp_q.push_back(e);

    @(negedge clk);
    icache_req  = 1;
    icache_addr = addr;
    fence_i     = (fmode == 1);
    @(negedge clk);
    icache_req  = 0;
    fence_i     = 0;
    icache_addr = $urandom;
    lat = 1;
    while (lat < 20 && !icache_ready && !mem_req) begin
      @(negedge clk);
      lat++;
    end
    if (mem_req) begin
      check("miss_latency", lat, 2);
      d = $urandom_range(0, 3);
      if (fmode == 2 && d == 0) d = 1;
      for (int k = 0; k < d; k++) begin
        fence_i  = (fmode == 2 && k == 0);
        mem_data = rand_block();
        @(negedge clk);
      end
      fence_i   = (fmode == 3);
      mem_ready = 1;
      mem_err   = err;
      mem_data  = blk;
      @(negedge clk);
      mem_ready = 0;
      mem_err   = 0;
      fence_i   = 0;
      mem_data  = rand_block();
    end else if (icache_ready) begin
      check("hit_latency", lat, 2);
    end else begin
      check("txn_timeout", lat, 0);
      abort = 1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    case ($urandom_range(0, 2))
      0:       base = 32'h8000_0000;
      1:       base = 32'h8000_0100;
      default: base = 32'hA000_0000;
    endcase
    return base | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    logic [LW-1:0] b;
    int r;
    int lat;
    rst = 1; icache_req = 0; icache_addr = 0; mem_data = 0;
    mem_ready = 0; mem_err = 0; fence_i = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_hit", {31'd0, icache_hit}, 32'd0);
    check("rst_data", icache_data, 32'd0);
    check("rst_ready", {31'd0, icache_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);

    // Cold miss then re-hit.
    b = rand_block(); b[31:0] = 32'h0000_0413;
    txn(32'h8000_0000, 0, 0, b);
    txn(32'h8000_0000, 0, 0, rand_block());
    // Conflict eviction of the same slot, then the original misses again.
    txn(32'h8000_0100, 0, 0, rand_block());
    txn(32'h8000_0000, 0, 0, rand_block());
    txn(32'h8000_0000, 0, 0, rand_block());
    // Fence with the request, fence on the mem_ready cycle, fence mid-refill.
    txn(32'h8000_0000, 0, 1, rand_block());
    txn(32'h8000_0010, 0, 3, rand_block());
    txn(32'h8000_0010, 0, 0, rand_block());
    txn(32'h8000_0020, 0, 2, rand_block());
    txn(32'h8000_0020, 0, 0, rand_block());
    txn(32'h8000_0020, 0, 0, rand_block());
    // Faulted refill is not cached.
    txn(32'hA000_0000, 1, 0, rand_block());
    txn(32'hA000_0000, 0, 0, rand_block());
    // Word selection within a 16-byte line.
    txn(32'hA000_0048, 0, 0, rand_block());
    txn(32'hA000_004C, 0, 0, rand_block());

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 15);
      txn(rand_addr(), ($urandom_range(0, 7) == 0), (r < 12) ? 0 : r - 12 + 1 - ((r == 15) ? 1 : 0),
          rand_block());
    end

    // Reset during an outstanding refill.
    txn(32'h8000_0000, 0, 0, rand_block());
    txn(32'h8000_0000, 0, 0, rand_block());
    if (!abort) begin
      refill_q.push_back(32'hC000_0000);
      @(negedge clk);
      icache_req = 1; icache_addr = 32'hC000_0004;
      @(negedge clk);
      icache_req = 0;
      lat = 0;
      while (lat < 20 && !mem_req) begin
        @(negedge clk);
        lat++;
      end
      check("rst_test_mem_req_seen", {31'd0, mem_req}, 32'd1);
      #2 rst = 1;
      #1 check("mem_req_async_clear", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      rst = 0;
      m_reset();
      check("post_rst_hit_cnt", hit_cnt, 32'd0);
      check("post_rst_miss_cnt", miss_cnt, 32'd0);
      mem_ready = 1; mem_data = rand_block();
      @(negedge clk);
      mem_ready = 0;
      @(negedge clk);
      check("stale_ready_ignored", {31'd0, icache_ready}, 32'd0);
      txn(32'h8000_0000, 0, 0, rand_block());
      txn(32'h8000_0000, 0, 0, rand_block());
    end

    repeat (3) @(negedge clk);
    check("pending_responses", 32'(exp_q.size()), 32'd0);
    check("pending_refills", 32'(refill_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
